vec_mac_accum: RTL and testbench



---
 rtl/vec_mac_accum.sv | 137 +++++++++++++
 tb/tb_vec_mac_accum.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mac_accum.sv
// vec_mac_accum: 4-lane unsigned dot-product accumulator.
// It runs a three-stage pipeline (multiply, lane-sum, accumulate) and sums
// NUM_VEC accepted beats into one result. The result is then presented on a
// valid/ready output handshake.
// Optional feature: define VEC_MAC_SATURATE_EN to make the accumulator clamp
// at 2^ACC_W-1 on overflow. The default build wraps modulo 2^ACC_W instead.
module vec_mac_accum #(
  parameter int LANE_W  = 16,
  parameter int NUM_VEC = 16,
  parameter int ACC_W   = 40
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*LANE_W-1:0]   a_in,
  input  logic [4*LANE_W-1:0]   b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      acc_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int PROD_W = 2 * LANE_W;
  localparam int SUM_W  = 2 * LANE_W + 2;
  localparam int CNT_W  = $clog2(NUM_VEC + 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ACC_W-1:0]      acc_q;
  logic                  ovf_q;
  logic                  out_valid_q;

  logic [PROD_W-1:0]     prod_q [4];
  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic [SUM_W-1:0]      sum_q;
  logic                  s2_valid_q;
  logic                  s2_last_q;

  logic                  accept;
  logic                  last_accept;
  logic [ACC_W:0]        add_d;
  logic [ACC_W-1:0]      acc_d;
  logic                  ovf_d;

  assign in_ready    = (state_q == ACCUM);
  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (cnt_q == CNT_W'(NUM_VEC - 1));

  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != ACCUM) | s1_valid_q | s2_valid_q;

  // Stage-3 adder: the extra top bit is the carry-out that signals overflow.
  always_comb begin
    add_d = {1'b0, acc_q} + (ACC_W + 1)'(sum_q);
    ovf_d = ovf_q | add_d[ACC_W];
`ifdef VEC_MAC_SATURATE_EN
    // Once saturated, the accumulator stays pinned for the rest of the result.
    acc_d = ovf_d ? {ACC_W{1'b1}} : add_d[ACC_W-1:0];
`else
    acc_d = add_d[ACC_W-1:0];
`endif
  end

  // Stages 1 and 2: lane products are captured on accept, then the lane sum.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) prod_q[k] <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      sum_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= last_accept;
      if (accept) begin
        for (int k = 0; k < 4; k++)
          prod_q[k] <= a_in[k*LANE_W +: LANE_W] * b_in[k*LANE_W +: LANE_W];
      end
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q)
        sum_q <= SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) +
                 SUM_W'(prod_q[2]) + SUM_W'(prod_q[3]);
    end
  end

  // Control FSM: beat counting, accumulation, and the result handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s2_valid_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
      case (state_q)
        ACCUM: begin
          if (accept) cnt_q <= cnt_q + 1'b1;
          if (last_accept) state_q <= DRAIN;
        end
        DRAIN: begin
          if (s2_valid_q && s2_last_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mac_accum.sv
// Scoreboard testbench for vec_mac_accum.
// Two instances share the same stimulus. One uses a 40-bit accumulator and
// the other a 36-bit accumulator, so the all-0xFFFF run exercises overflow.
module tb_vec_mac_accum;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [63:0] a_in, b_in;
  logic        out_ready;
  logic        in_ready, out_valid, overflow, busy;
  logic [39:0] acc_out;
  logic        in_ready36, out_valid36, overflow36, busy36;
  logic [35:0] acc_out36;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_cyc;

  typedef struct {
    logic [39:0] acc;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q40[$];
  exp_t q36[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_mac_accum #(.LANE_W(16), .NUM_VEC(16), .ACC_W(40)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .busy(busy)
  );

  vec_mac_accum #(.LANE_W(16), .NUM_VEC(16), .ACC_W(36)) dut36 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready36),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid36), .out_ready(out_ready),
    .acc_out(acc_out36), .overflow(overflow36), .busy(busy36)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 40-bit instance: checks the result as it appears and
  // while it is held.
  logic        prev40 = 1'b0;
  exp_t        cur40;
  always @(negedge clk) begin
    if (!resetn) prev40 <= 1'b0;
    else begin
      if (out_valid && !prev40) begin
        if (q40.size() == 0) begin
          chk("unexpected_result40", 64'(acc_out), 64'hDEAD);
        end else begin
          cur40 = q40.pop_front();
          chk("acc40", 64'(acc_out), 64'(cur40.acc));
          chk("ovf40", 64'(overflow), 64'(cur40.ovf));
          chk("latency40", 64'(cyc), 64'(cur40.cyc));
          $display("result40 acc=%h ovf=%0d cycle=%0d", acc_out, overflow, cyc);
        end
      end else if (out_valid) begin
        chk("hold_acc40", 64'(acc_out), 64'(cur40.acc));
        chk("hold_inready40", 64'(in_ready), 64'd0);
      end
      prev40 <= out_valid;
    end
  end

  // Monitor for the 36-bit instance.
  logic        prev36 = 1'b0;
  exp_t        cur36;
  always @(negedge clk) begin
    if (!resetn) prev36 <= 1'b0;
    else begin
      if (out_valid36 && !prev36) begin
        if (q36.size() == 0) begin
          chk("unexpected_result36", 64'(acc_out36), 64'hDEAD);
        end else begin
          cur36 = q36.pop_front();
          chk("acc36", 64'(acc_out36), 64'(cur36.acc));
          chk("ovf36", 64'(overflow36), 64'(cur36.ovf));
          chk("latency36", 64'(cyc), 64'(cur36.cyc));
          $display("result36 acc=%h ovf=%0d cycle=%0d", acc_out36, overflow36, cyc);
        end
      end else if (out_valid36) begin
        chk("hold_acc36", 64'(acc_out36), 64'(cur36.acc));
      end
      prev36 <= out_valid36;
    end
  end

  // Sends n accepted beats, with optional random bubbles between them.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input int n, input bit gaps);
    int got = 0;
    int guard = 0;
    logic v;
    while (got < n && guard < 2000) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
      end
      v = in_valid & in_ready;
      @(posedge clk); #1;
      if (v) begin
        got++;
        last_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    if (got < n) chk("send_timeout", 64'(got), 64'(n));
  endtask

  task automatic push(input logic [39:0] e40, input logic o40, input logic [39:0] e36, input logic o36);
    exp_t e;
    e.cyc = last_cyc + 2;
    e.acc = e40; e.ovf = o40; q40.push_back(e);
    e.acc = e36; e.ovf = o36; q36.push_back(e);
  endtask

  // Waits for a result, holds it for `hold` cycles (optionally toggling
  // in_valid with junk data), then completes the handshake.
  task automatic take(input int hold, input bit junk);
    int g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!out_valid) chk("result_timeout", 64'(out_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        in_valid = i[0];
        a_in = '1;
        b_in = '1;
      end
      chk("hold_inready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_acc", 64'(acc_out), 64'd0);
    chk("post_ovf", 64'(overflow), 64'd0);
    chk("post_outvalid", 64'(out_valid), 64'd0);
    chk("post_inready", 64'(in_ready), 64'd1);
    chk("post_acc36", 64'(acc_out36), 64'd0);
  endtask

  initial begin
    logic [39:0] exp36_full;
    resetn = 1'b0;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    out_ready = 1'b0;
    last_cyc = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_outvalid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_inready", 64'(in_ready), 64'd1);
    $display("reset checked");

    // Basic: 16 beats of a=1, b=2 on all lanes -> 16*4*2 = 128.
    send({4{16'd1}}, {4{16'd2}}, 16, 1'b0);
    push(40'd128, 1'b0, 40'd128, 1'b0);
    take(0, 1'b0);

    // Full range: 16 * 4 * 0xFFFE0001 = 0x3FFF800040. On the 36-bit
    // instance this overflows: it wraps to 0xFFF800040 or saturates.
`ifdef VEC_MAC_SATURATE_EN
    exp36_full = 40'hF_FFFF_FFFF;
`else
    exp36_full = 40'hF_FF80_0040;
`endif
    send({4{16'hFFFF}}, {4{16'hFFFF}}, 16, 1'b0);
    push(40'h3F_FF80_0040, 1'b0, exp36_full, 1'b1);
    take(2, 1'b0);

    // Bubbles and backpressure: a lanes 1..4, b=3 -> 16*3*10 = 480.
    send({16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd3}}, 16, 1'b1);
    push(40'd480, 1'b0, 40'd480, 1'b0);
    take(10, 1'b1);

    // Reset in the middle of a result, then a clean run.
    send({4{16'd7}}, {4{16'd9}}, 8, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_acc", 64'(acc_out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_outvalid", 64'(out_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("midrst_inready", 64'(in_ready), 64'd1);
    send({4{16'd1}}, {4{16'd2}}, 16, 1'b0);
    push(40'd128, 1'b0, 40'd128, 1'b0);
    take(1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q40_drained", 64'(q40.size()), 64'd0);
    chk("q36_drained", 64'(q36.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
